// File: rtl/gpu_pkg.sv
// Shared constants and types for the GPU framebuffer SRAM path.
package gpu_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int FB_W   = 640;
    localparam int FB_H   = 400;

    // The arbiter state is the SRAM command being driven in the current cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/gpu_wfifo.sv
// GPU write buffer: synchronous FIFO of {addr,data} entries with occupancy level.
module gpu_wfifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             I_CLK,
    input  logic             I_RST_N,
    input  logic             push_i,
    input  wr_entry_t        push_entry_i,
    input  logic             pop_i,
    output wr_entry_t        head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    wr_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == DEPTH_L);
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end

endmodule

// File: rtl/gpu_sram_arb.sv
// Single-port SRAM arbiter: display reads always win, GPU writes drain from a buffer.
module gpu_sram_arb
    import gpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = 3
) (
    input  logic              I_CLK,
    input  logic              I_RST_N,
    input  logic              I_VIDEO_ON,
    input  logic              I_DISP_REQ,
    input  logic [ADDR_W-1:0] I_DISP_ADDR,
    output logic [DATA_W-1:0] O_DISP_DATA,
    output logic              O_DISP_VALID,
    input  logic              I_GPU_WREQ,
    input  logic [ADDR_W-1:0] I_GPU_WADDR,
    input  logic [DATA_W-1:0] I_GPU_WDATA,
    output logic              O_GPU_WREADY,
    output logic [ADDR_W-1:0] O_SRAM_ADDR,
    output logic [DATA_W-1:0] O_SRAM_DATA,
    output logic              O_SRAM_READ,
    output logic              O_SRAM_WRITE,
    input  logic [DATA_W-1:0] I_SRAM_DATA,
    output logic [LVL_W-1:0]  O_FIFO_LEVEL,
    output logic [15:0]       O_WR_COUNT
);

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    arb_state_e        state_q;
    arb_state_e        state_d;
    wr_entry_t         push_entry;
    wr_entry_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] sdata_q;
    logic [DATA_W-1:0] disp_data_q;
    logic              disp_valid_q;
    logic [15:0]       wr_count_q;
    logic              unused_status;

    // Video window is informational only; the buffer guards itself with full_o.
    assign unused_status = ^{I_VIDEO_ON, fifo_full};

    assign push_entry.addr = I_GPU_WADDR;
    assign push_entry.data = I_GPU_WDATA;
    assign O_GPU_WREADY    = (fifo_level < DEPTH_L);
    assign push            = I_GPU_WREQ && O_GPU_WREADY;
    assign pop             = (state_d == ST_WR);

    gpu_wfifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_wfifo (
        .I_CLK        (I_CLK),
        .I_RST_N      (I_RST_N),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .level_o      (fifo_level)
    );

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = ST_IDLE;
        if (I_DISP_REQ)       state_d = ST_RD;
        else if (!fifo_empty) state_d = ST_WR;
    end

    // Command regs load at the granting edge; read data returns one cycle after READ.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            addr_q       <= '0;
            sdata_q      <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            wr_count_q   <= '0;
        end else begin
            if (state_d == ST_RD) begin
                addr_q <= I_DISP_ADDR;
            end else if (state_d == ST_WR) begin
                addr_q  <= head.addr;
                sdata_q <= head.data;
            end
            disp_valid_q <= (state_q == ST_RD);
            if (state_q == ST_RD) disp_data_q <= I_SRAM_DATA;
            if (state_q == ST_WR) wr_count_q <= wr_count_q + 16'd1;
        end
    end

    assign O_SRAM_READ  = (state_q == ST_RD);
    assign O_SRAM_WRITE = (state_q == ST_WR);
    assign O_SRAM_ADDR  = addr_q;
    assign O_SRAM_DATA  = sdata_q;
    assign O_DISP_DATA  = disp_data_q;
    assign O_DISP_VALID = disp_valid_q;
    assign O_FIFO_LEVEL = fifo_level;
    assign O_WR_COUNT   = wr_count_q;

endmodule

// File: tb/tb_gpu_sram_arb.sv
// Bench for gpu_sram_arb: directed vector table, corner sequences, random traffic vs queue model.
module tb_gpu_sram_arb;

    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = 3;

    logic        I_CLK;
    logic        I_RST_N;
    logic        I_VIDEO_ON;
    logic        I_DISP_REQ;
    logic [17:0] I_DISP_ADDR;
    logic [15:0] O_DISP_DATA;
    logic        O_DISP_VALID;
    logic        I_GPU_WREQ;
    logic [17:0] I_GPU_WADDR;
    logic [15:0] I_GPU_WDATA;
    logic        O_GPU_WREADY;
    logic [17:0] O_SRAM_ADDR;
    logic [15:0] O_SRAM_DATA;
    logic        O_SRAM_READ;
    logic        O_SRAM_WRITE;
    logic [15:0] I_SRAM_DATA;
    logic [2:0]  O_FIFO_LEVEL;
    logic [15:0] O_WR_COUNT;

    gpu_sram_arb #(.FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) dut (
        .I_CLK        (I_CLK),
        .I_RST_N      (I_RST_N),
        .I_VIDEO_ON   (I_VIDEO_ON),
        .I_DISP_REQ   (I_DISP_REQ),
        .I_DISP_ADDR  (I_DISP_ADDR),
        .O_DISP_DATA  (O_DISP_DATA),
        .O_DISP_VALID (O_DISP_VALID),
        .I_GPU_WREQ   (I_GPU_WREQ),
        .I_GPU_WADDR  (I_GPU_WADDR),
        .I_GPU_WDATA  (I_GPU_WDATA),
        .O_GPU_WREADY (O_GPU_WREADY),
        .O_SRAM_ADDR  (O_SRAM_ADDR),
        .O_SRAM_DATA  (O_SRAM_DATA),
        .O_SRAM_READ  (O_SRAM_READ),
        .O_SRAM_WRITE (O_SRAM_WRITE),
        .I_SRAM_DATA  (I_SRAM_DATA),
        .O_FIFO_LEVEL (O_FIFO_LEVEL),
        .O_WR_COUNT   (O_WR_COUNT)
    );

    initial begin
        I_CLK = 1'b0;
        forever #5 I_CLK = ~I_CLK;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        else n_pass++;
    endtask

    // Reference model: the buffer is a queue, the SRAM bus is the last granted command.
    typedef struct { logic [17:0] addr; logic [15:0] data; } ent_t;
    ent_t        m_q[$];
    logic        m_read, m_write, m_valid;
    logic [17:0] m_addr;
    logic [15:0] m_data, m_ddata, m_cnt;

    task automatic model_clear();
        m_q.delete();
        m_read = 0; m_write = 0; m_valid = 0;
        m_addr = '0; m_data = '0; m_ddata = '0; m_cnt = '0;
    endtask

    task automatic model_edge();
        ent_t e;
        bit   can_accept;
        can_accept = (m_q.size() < FIFO_DEPTH);
        m_valid = m_read;
        if (m_read)  m_ddata = I_SRAM_DATA;
        if (m_write) m_cnt = m_cnt + 16'd1;
        if (I_DISP_REQ) begin
            m_read = 1; m_write = 0; m_addr = I_DISP_ADDR;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_read = 0; m_write = 1; m_addr = e.addr; m_data = e.data;
        end else begin
            m_read = 0; m_write = 0;
        end
        if (I_GPU_WREQ && can_accept) begin
            e.addr = I_GPU_WADDR; e.data = I_GPU_WDATA;
            m_q.push_back(e);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".read"},   32'(O_SRAM_READ),  32'(m_read));
        chk({tag, ".write"},  32'(O_SRAM_WRITE), 32'(m_write));
        chk({tag, ".addr"},   32'(O_SRAM_ADDR),  32'(m_addr));
        chk({tag, ".sdata"},  32'(O_SRAM_DATA),  32'(m_data));
        chk({tag, ".valid"},  32'(O_DISP_VALID), 32'(m_valid));
        chk({tag, ".ddata"},  32'(O_DISP_DATA),  32'(m_ddata));
        chk({tag, ".level"},  32'(O_FIFO_LEVEL), 32'(m_q.size()));
        chk({tag, ".wready"}, 32'(O_GPU_WREADY), 32'(m_q.size() < FIFO_DEPTH));
        chk({tag, ".count"},  32'(O_WR_COUNT),   32'(m_cnt));
    endtask

    task automatic tick();
        model_edge();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".read"},   32'(O_SRAM_READ),  32'd0);
        chk({tag, ".write"},  32'(O_SRAM_WRITE), 32'd0);
        chk({tag, ".addr"},   32'(O_SRAM_ADDR),  32'd0);
        chk({tag, ".sdata"},  32'(O_SRAM_DATA),  32'd0);
        chk({tag, ".ddata"},  32'(O_DISP_DATA),  32'd0);
        chk({tag, ".valid"},  32'(O_DISP_VALID), 32'd0);
        chk({tag, ".level"},  32'(O_FIFO_LEVEL), 32'd0);
        chk({tag, ".wready"}, 32'(O_GPU_WREADY), 32'd1);
        chk({tag, ".count"},  32'(O_WR_COUNT),   32'd0);
    endtask

    // Asserts reset off-edge, checks the asynchronous clear, holds across one edge, releases.
    task automatic apply_reset(input string tag);
        I_RST_N = 1'b0;
        #1;
        check_reset_values(tag);
        model_clear();
        @(posedge I_CLK);
        #1;
        check_reset_values({tag, "_held"});
        I_RST_N = 1'b1;
    endtask

    typedef struct {
        logic        dreq;
        logic [17:0] daddr;
        logic        wreq;
        logic [17:0] waddr;
        logic [15:0] wdata;
        logic [15:0] sram;
        logic        e_rd;
        logic        e_wr;
        logic [17:0] e_addr;
        logic [15:0] e_sdata;
        logic [2:0]  e_lvl;
        logic        e_wrdy;
        logic        e_vld;
        logic [15:0] e_ddata;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[18];

    initial begin
        // dreq daddr wreq waddr wdata sram | rd wr addr sdata lvl wrdy vld ddata cnt
        vecs[0]  = '{1'b1, 18'h00100, 1'b0, 18'h00000, 16'h0000, 16'h0000, 1'b1, 1'b0, 18'h00100, 16'h0000, 3'd0, 1'b1, 1'b0, 16'h0000, 16'd0};
        vecs[1]  = '{1'b1, 18'h00200, 1'b1, 18'h00000, 16'h0F00, 16'h0F00, 1'b1, 1'b0, 18'h00200, 16'h0000, 3'd1, 1'b1, 1'b1, 16'h0F00, 16'd0};
        vecs[2]  = '{1'b1, 18'h00300, 1'b1, 18'h00001, 16'h0F01, 16'h1234, 1'b1, 1'b0, 18'h00300, 16'h0000, 3'd2, 1'b1, 1'b1, 16'h1234, 16'd0};
        vecs[3]  = '{1'b1, 18'h00300, 1'b1, 18'h00002, 16'h0F02, 16'h5678, 1'b1, 1'b0, 18'h00300, 16'h0000, 3'd3, 1'b1, 1'b1, 16'h5678, 16'd0};
        vecs[4]  = '{1'b1, 18'h00300, 1'b1, 18'h00003, 16'h0F03, 16'h9ABC, 1'b1, 1'b0, 18'h00300, 16'h0000, 3'd4, 1'b0, 1'b1, 16'h9ABC, 16'd0};
        vecs[5]  = '{1'b1, 18'h00300, 1'b1, 18'h3FFFF, 16'h0FFF, 16'h1111, 1'b1, 1'b0, 18'h00300, 16'h0000, 3'd4, 1'b0, 1'b1, 16'h1111, 16'd0};
        vecs[6]  = '{1'b0, 18'h00300, 1'b1, 18'h3FFFF, 16'h0FFF, 16'h2222, 1'b0, 1'b1, 18'h00000, 16'h0F00, 3'd3, 1'b1, 1'b1, 16'h2222, 16'd0};
        vecs[7]  = '{1'b0, 18'h00000, 1'b0, 18'h00000, 16'h0000, 16'h3333, 1'b0, 1'b1, 18'h00001, 16'h0F01, 3'd2, 1'b1, 1'b0, 16'h2222, 16'd1};
        vecs[8]  = '{1'b0, 18'h00000, 1'b0, 18'h00000, 16'h0000, 16'h0000, 1'b0, 1'b1, 18'h00002, 16'h0F02, 3'd1, 1'b1, 1'b0, 16'h2222, 16'd2};
        vecs[9]  = '{1'b0, 18'h00000, 1'b0, 18'h00000, 16'h0000, 16'h0000, 1'b0, 1'b1, 18'h00003, 16'h0F03, 3'd0, 1'b1, 1'b0, 16'h2222, 16'd3};
        vecs[10] = '{1'b0, 18'h00000, 1'b0, 18'h00000, 16'h0000, 16'h0000, 1'b0, 1'b0, 18'h00003, 16'h0F03, 3'd0, 1'b1, 1'b0, 16'h2222, 16'd4};
        vecs[11] = '{1'b1, 18'h00010, 1'b1, 18'h2000A, 16'h0A10, 16'h0000, 1'b1, 1'b0, 18'h00010, 16'h0F03, 3'd1, 1'b1, 1'b0, 16'h2222, 16'd4};
        vecs[12] = '{1'b1, 18'h00011, 1'b1, 18'h2000B, 16'h0A11, 16'h4444, 1'b1, 1'b0, 18'h00011, 16'h0F03, 3'd2, 1'b1, 1'b1, 16'h4444, 16'd4};
        vecs[13] = '{1'b0, 18'h00000, 1'b1, 18'h2000C, 16'h0A12, 16'h5555, 1'b0, 1'b1, 18'h2000A, 16'h0A10, 3'd2, 1'b1, 1'b1, 16'h5555, 16'd4};
        vecs[14] = '{1'b1, 18'h00020, 1'b1, 18'h2000D, 16'h0A13, 16'h0000, 1'b1, 1'b0, 18'h00020, 16'h0A10, 3'd3, 1'b1, 1'b0, 16'h5555, 16'd5};
        vecs[15] = '{1'b1, 18'h00021, 1'b1, 18'h2000E, 16'h0A14, 16'h7777, 1'b1, 1'b0, 18'h00021, 16'h0A10, 3'd4, 1'b0, 1'b1, 16'h7777, 16'd5};
        vecs[16] = '{1'b0, 18'h00000, 1'b1, 18'h2000F, 16'h0A15, 16'h8888, 1'b0, 1'b1, 18'h2000B, 16'h0A11, 3'd3, 1'b1, 1'b1, 16'h8888, 16'd5};
        vecs[17] = '{1'b0, 18'h00000, 1'b0, 18'h00000, 16'h0000, 16'h9999, 1'b0, 1'b1, 18'h2000C, 16'h0A12, 3'd2, 1'b1, 1'b0, 16'h8888, 16'd6};

        I_RST_N = 1'b1;
        I_VIDEO_ON = 1'b0; I_DISP_REQ = 1'b0; I_DISP_ADDR = '0;
        I_GPU_WREQ = 1'b0; I_GPU_WADDR = '0; I_GPU_WDATA = '0; I_SRAM_DATA = '0;
        model_clear();
        #2;
        apply_reset("reset");

        // Directed table: read latency, fill to full, drain in order, push+pop and full+pop.
        for (int i = 0; i < 18; i++) begin
            I_DISP_REQ  = vecs[i].dreq;  I_DISP_ADDR = vecs[i].daddr;
            I_GPU_WREQ  = vecs[i].wreq;  I_GPU_WADDR = vecs[i].waddr;
            I_GPU_WDATA = vecs[i].wdata; I_SRAM_DATA = vecs[i].sram;
            tick();
            chk($sformatf("vec%0d.read", i),   32'(O_SRAM_READ),  32'(vecs[i].e_rd));
            chk($sformatf("vec%0d.write", i),  32'(O_SRAM_WRITE), 32'(vecs[i].e_wr));
            chk($sformatf("vec%0d.addr", i),   32'(O_SRAM_ADDR),  32'(vecs[i].e_addr));
            chk($sformatf("vec%0d.sdata", i),  32'(O_SRAM_DATA),  32'(vecs[i].e_sdata));
            chk($sformatf("vec%0d.level", i),  32'(O_FIFO_LEVEL), 32'(vecs[i].e_lvl));
            chk($sformatf("vec%0d.wready", i), 32'(O_GPU_WREADY), 32'(vecs[i].e_wrdy));
            chk($sformatf("vec%0d.valid", i),  32'(O_DISP_VALID), 32'(vecs[i].e_vld));
            chk($sformatf("vec%0d.ddata", i),  32'(O_DISP_DATA),  32'(vecs[i].e_ddata));
            chk($sformatf("vec%0d.count", i),  32'(O_WR_COUNT),   32'(vecs[i].e_cnt));
            $display("vec %0d: rd=%0b wr=%0b addr=%05h sdata=%04h lvl=%0d vld=%0b ddata=%04h cnt=%0d",
                     i, O_SRAM_READ, O_SRAM_WRITE, O_SRAM_ADDR, O_SRAM_DATA, O_FIFO_LEVEL,
                     O_DISP_VALID, O_DISP_DATA, O_WR_COUNT);
        end

        // Random traffic, light then heavy display load, against the queue model.
        for (int i = 0; i < 600; i++) begin
            I_VIDEO_ON  = 1'($urandom_range(0, 1));
            I_DISP_REQ  = ($urandom_range(0, 99) < ((i < 300) ? 30 : 70));
            I_DISP_ADDR = 18'($urandom);
            I_GPU_WREQ  = ($urandom_range(0, 99) < 75);
            I_GPU_WADDR = 18'($urandom);
            I_GPU_WDATA = {4'h0, 12'($urandom)};
            I_SRAM_DATA = 16'($urandom);
            tick();
            check_model($sformatf("rand%0d", i));
            if (i % 50 == 0)
                $display("rand %0d: rd=%0b wr=%0b addr=%05h lvl=%0d cnt=%0d", i,
                         O_SRAM_READ, O_SRAM_WRITE, O_SRAM_ADDR, O_FIFO_LEVEL, O_WR_COUNT);
        end

        // Reset with three buffered writes and a read in flight.
        I_DISP_REQ = 1'b0; I_GPU_WREQ = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 3; i++) begin
            I_DISP_REQ  = 1'b1; I_DISP_ADDR = 18'h00100 + 18'(i);
            I_GPU_WREQ  = 1'b1; I_GPU_WADDR = 18'h10000 + 18'(i); I_GPU_WDATA = 16'h0C00 + 16'(i);
            I_SRAM_DATA = 16'h0;
            tick();
            check_model($sformatf("prerst%0d", i));
        end
        chk("prerst.level", 32'(O_FIFO_LEVEL), 32'd3);
        chk("prerst.read",  32'(O_SRAM_READ),  32'd1);
        I_DISP_REQ = 1'b0; I_GPU_WREQ = 1'b0; I_SRAM_DATA = 16'hDEAD;
        apply_reset("midrst");
        $display("midrst: lvl=%0d vld=%0b wr=%0b cnt=%0d", O_FIFO_LEVEL, O_DISP_VALID, O_SRAM_WRITE, O_WR_COUNT);

        // First grant happens on the first edge after release; no stale VALID or WRITE.
        I_DISP_REQ = 1'b1; I_DISP_ADDR = 18'h2ABCD; I_SRAM_DATA = 16'hBEEF;
        tick();
        check_model("postrst0");
        chk("postrst0.read",  32'(O_SRAM_READ),  32'd1);
        chk("postrst0.addr",  32'(O_SRAM_ADDR),  32'h2ABCD);
        chk("postrst0.valid", 32'(O_DISP_VALID), 32'd0);
        chk("postrst0.write", 32'(O_SRAM_WRITE), 32'd0);
        I_DISP_REQ = 1'b0;
        tick();
        check_model("postrst1");
        chk("postrst1.valid", 32'(O_DISP_VALID), 32'd1);
        chk("postrst1.ddata", 32'(O_DISP_DATA),  32'hBEEF);
        chk("postrst1.write", 32'(O_SRAM_WRITE), 32'd0);
        $display("postrst: vld=%0b ddata=%04h wr=%0b", O_DISP_VALID, O_DISP_DATA, O_SRAM_WRITE);

        // Stream one write per cycle until the completed-write count reaches 16'hFFFF.
        I_GPU_WREQ = 1'b1;
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) begin
            I_GPU_WADDR = 18'($urandom);
            I_GPU_WDATA = {4'h0, 12'($urandom)};
            tick();
            if (i % 256 == 0 || m_cnt == 16'hFFFF) check_model("stream");
        end
        chk("wrap.pre", 32'(O_WR_COUNT), 32'h0000FFFF);
        chk("wrap.wr",  32'(O_SRAM_WRITE), 32'd1);
        I_GPU_WREQ = 1'b0;
        tick();
        check_model("wrap");
        chk("wrap.post", 32'(O_WR_COUNT), 32'd0);
        $display("wrap: cnt=%0d", O_WR_COUNT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpu_sram_arb.md
GPU_SRAM_ARB -- requirements
Module: gpu_sram_arb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, GPU write-buffer entries (power of 2, 2..16).
REQ-002 SHALL have parameter LVL_W, default 3, width of O_FIFO_LEVEL (log2(FIFO_DEPTH)+1).
REQ-003 SHALL have port I_CLK  in  1  clock; all state updates on posedge.
REQ-004 SHALL have port I_RST_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port I_VIDEO_ON  in  1  display active window; status input only, gates nothing.
REQ-006 SHALL have port I_DISP_REQ  in  1  display pixel read request.
REQ-007 SHALL have port I_DISP_ADDR  in  18  display read address.
REQ-008 SHALL have port O_DISP_DATA  out  16  display read data.
REQ-009 SHALL have port O_DISP_VALID  out  1  O_DISP_DATA valid, one-cycle pulse per read.
REQ-010 SHALL have port I_GPU_WREQ  in  1  GPU write request.
REQ-011 SHALL have port I_GPU_WADDR  in  18  GPU write address.
REQ-012 SHALL have port I_GPU_WDATA  in  16  GPU write pixel {4'h0,R,G,B}.
REQ-013 SHALL have port O_GPU_WREADY  out  1  write buffer can accept.
REQ-014 SHALL have port O_SRAM_ADDR  out  18, O_SRAM_DATA out 16, O_SRAM_READ out 1, O_SRAM_WRITE out 1: registered SRAM command.
REQ-015 SHALL have port I_SRAM_DATA  in  16  SRAM read data.
REQ-016 SHALL have ports O_FIFO_LEVEL  out  LVL_W  buffered writes, and O_WR_COUNT  out  16  completed writes.

Function
REQ-017 A write SHALL be accepted in a cycle exactly when I_GPU_WREQ && O_GPU_WREADY; O_GPU_WREADY = (O_FIFO_LEVEL < FIFO_DEPTH), taken from the registered level.
REQ-018 When full, a pop in the same cycle SHALL NOT let a push be accepted (WREADY stays 0 that cycle).
REQ-019 Arbiter FSM states SHALL be IDLE, RD, WR; the state is the command driven in the next cycle.
REQ-020 Transition priority from any state: I_DISP_REQ -> RD; else FIFO non-empty -> WR; else IDLE.
REQ-021 Display reads SHALL always win; a write SHALL issue only in cycles with I_DISP_REQ low.
REQ-022 RD: O_SRAM_READ=1, O_SRAM_WRITE=0, O_SRAM_ADDR=I_DISP_ADDR sampled at the granting edge.
REQ-023 WR: O_SRAM_WRITE=1, O_SRAM_READ=0, addr/data = FIFO head; pop at the granting edge.
REQ-024 IDLE: READ=WRITE=0; O_SRAM_ADDR and O_SRAM_DATA hold their last values.
REQ-025 Read latency: I_DISP_REQ high in cycle c -> SRAM read in c+1 -> O_DISP_VALID=1 with I_SRAM_DATA (sampled at end of c+1) in c+2; fully pipelined, one read per cycle.
REQ-026 O_DISP_DATA SHALL hold between pulses.
REQ-027 O_FIFO_LEVEL SHALL be +1 on push only, -1 on pop only, unchanged on both or neither; never above FIFO_DEPTH or below 0.
REQ-028 FIFO SHALL be strict FIFO order; pointers wrap modulo FIFO_DEPTH.
REQ-029 O_WR_COUNT SHALL increment on each WR cycle and wrap 16'hFFFF -> 0.
REQ-030 Address range SHALL NOT be checked; any 18-bit value passes through.

Reset
REQ-031 Asserting I_RST_N low SHALL immediately set: state IDLE, O_SRAM_READ=0, O_SRAM_WRITE=0, O_SRAM_ADDR=0, O_SRAM_DATA=0, O_DISP_DATA=0, O_DISP_VALID=0, O_FIFO_LEVEL=0, O_WR_COUNT=0; O_GPU_WREADY=1 follows from level 0.
REQ-032 Reset mid-operation SHALL discard buffered writes and in-flight reads: no VALID pulse and no SRAM write for pre-reset requests.
REQ-033 The first grant SHALL occur at the first posedge after deassertion.

Structure
REQ-034 Shared package gpu_pkg SHALL hold ADDR_W=18, DATA_W=16, FB_W=640, FB_H=400 and the arbiter state enum.
REQ-035 The write buffer SHALL be sub-module gpu_wfifo (sync FIFO: push/pop/full/empty/level); arbiter FSM, read pipeline and counter SHALL live in gpu_sram_arb.

Verification
REQ-036 Scenario: reset, then I_DISP_REQ=1 with ADDR=18'h00100 at c0, SRAM returns 16'h0F00 -> READ=1 addr 18'h00100 at c1; VALID=1 data 16'h0F00 at c2.
REQ-037 Scenario: push 4 writes (addr 0..3, data 16'h0F00..16'h0F03) with I_DISP_REQ=1 -> WREADY=0 after the 4th; level=4; no SRAM write; 5th request not accepted.
REQ-038 Scenario: drop I_DISP_REQ with level=4 -> 4 consecutive WR cycles in order addr 0..3; O_WR_COUNT=4; WREADY=1 after the first pop.
REQ-039 Scenario: level 2, push and pop in the same cycle -> level stays 2; full plus pop -> push rejected.
REQ-040 Scenario: reset pulse with level=3 and a read in flight -> no VALID, no write, level=0, all outputs at REQ-031 values.
REQ-041 Scenario: preload O_WR_COUNT to 16'hFFFF, then complete one write -> O_WR_COUNT=0.
